// File: rtl/vr16_pkg.sv
// Shared VR16 frontend definitions: data width, fetch FSM states and the
// {pc, instr} entry bundle carried from fetch to decode.
package vr16_pkg;

   localparam int XLEN = 16;
   localparam int ENTRY_W = 2 * XLEN;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DROP = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

   function automatic int entry_width(input int xlen);
      return 2 * xlen;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs for the decoder.
// Push and pop may coincide at any occupancy; flush empties it in one edge.
module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       head_valid,
   output logic [WIDTH-1:0]           head_data
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign do_pop  = pop && (count != '0);
   // A push into a full FIFO is only accepted when the head leaves in the same cycle
   assign do_push = push && ((count < CW'(DEPTH)) || do_pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + PW'(1);
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

   assign head_valid = (count != '0);
   assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// VR16 fetch stage: issues single-outstanding word reads at the current pc and
// buffers returned instructions; redirect flushes the buffer and drops in-flight data.
module instruction_fetch #(
   parameter int DEPTH = 2,
   parameter int XLEN  = 16
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [XLEN-1:0] pc,
   input  logic            redirect,
   input  logic            halt,
   output logic            pc_increment,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] instr_data,
   output logic [XLEN-1:0] instr_pc
);

   import vr16_pkg::*;

   localparam int CW         = $clog2(DEPTH + 1);
   localparam int ENTRY_BITS = entry_width(XLEN);

   fetch_state_t          state;
   fetch_state_t          next_state;
   logic [XLEN-1:0]       pending_pc;
   logic [CW-1:0]         count;
   logic [CW:0]           occupancy;
   logic                  outstanding;
   logic                  pop;
   logic                  issue;
   logic                  grant;
   logic                  push;
   logic [ENTRY_BITS-1:0] head;

   assign outstanding = (state != IDLE);
   assign pop         = instr_valid && instr_ready;
   // Slots committed after this edge; a pop never exceeds count, so no underflow
   assign occupancy   = {1'b0, count} + (CW+1)'(outstanding) - (CW+1)'(pop);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pending_pc <= '0;
      end else if (grant) begin
         pending_pc <= pc;
      end
   end

   always_comb begin
      next_state = state;
      unique case (state)
         IDLE: begin
            if (grant) next_state = WAIT;
         end
         WAIT: begin
            if (redirect) begin
               next_state = imem_rvalid ? IDLE : DROP;
            end else if (imem_rvalid) begin
               next_state = grant ? WAIT : IDLE;
            end
         end
         DROP: begin
            if (imem_rvalid) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   // A new request may overlap the cycle in which the previous one returns
   always_comb begin
      issue = !reset && !halt && !redirect
              && ((state == IDLE) || ((state == WAIT) && imem_rvalid))
              && (occupancy < (CW+1)'(DEPTH));
      grant = issue && imem_gnt;
      push  = !reset && !redirect && (state == WAIT) && imem_rvalid;
   end

   assign imem_req     = issue;
   assign imem_addr    = pc;
   assign pc_increment = grant;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENTRY_BITS)
   ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .push_data  ({pending_pc, imem_rdata}),
      .pop        (pop),
      .flush      (redirect),
      .count      (count),
      .head_valid (instr_valid),
      .head_data  (head)
   );

   assign instr_pc   = head[ENTRY_BITS-1:XLEN];
   assign instr_data = head[XLEN-1:0];

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: memory and program-counter models
// drive the DUT, and a queue of expected {pc, data} pairs tracks the decoder view.
module tb_instruction_fetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        redirect = 1'b0;
   logic        halt = 1'b0;
   logic [15:0] pc = '0;
   logic        pc_increment;
   logic        imem_req;
   logic [15:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [15:0] imem_rdata = '0;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [15:0] instr_data;
   logic [15:0] instr_pc;

   typedef struct {
      logic [15:0] pc;
      logic [15:0] data;
   } exp_t;

   exp_t        expQ[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] pc_tb = '0;
   bit          mem_busy = 1'b0;
   int          mem_left = 0;
   logic [15:0] mem_addr = '0;
   bit          tracks = 1'b0;
   bit          keep = 1'b0;
   bit          prev_rst = 1'b0;
   int          n_pop = 0;
   int          n_inc = 0;
   int          n_req = 0;

   instruction_fetch #(
      .DEPTH (DEPTH),
      .XLEN  (16)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .pc           (pc),
      .redirect     (redirect),
      .halt         (halt),
      .pc_increment (pc_increment),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_gnt     (imem_gnt),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .instr_valid  (instr_valid),
      .instr_ready  (instr_ready),
      .instr_data   (instr_data),
      .instr_pc     (instr_pc)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs after the edge, check before the next edge,
   // then advance the memory, counter and expected-queue models.
   task automatic applyStimulus(input bit rst, input bit redir, input logic [15:0] target,
                                input bit hlt, input bit rdy, input int gnt_pct, input int lat);
      bit   rsp_now;
      bit   exp_issue;
      bit   grant;
      bit   exp_pop;
      int   occ;
      exp_t ent;
      @(posedge clk);
      #1;
      rsp_now     = mem_busy && (mem_left == 0);
      reset       = rst;
      redirect    = redir;
      halt        = hlt;
      instr_ready = rdy;
      pc          = pc_tb;
      imem_rvalid = rsp_now;
      imem_rdata  = rsp_now ? (mem_addr ^ 16'hA5A5) : 16'($urandom);
      imem_gnt    = 1'b0;
      #1;
      imem_gnt = (!mem_busy || rsp_now) && ($urandom_range(99) < gnt_pct);
      #1;

      exp_pop   = (expQ.size() != 0) && rdy;
      occ       = expQ.size() + int'(tracks) - (exp_pop ? 1 : 0);
      exp_issue = !rst && !hlt && !redir && (!tracks || (keep && rsp_now)) && (occ < DEPTH);

      checkOutput("imem_req", imem_req, exp_issue);
      checkOutput("pc_increment", pc_increment, exp_issue && imem_gnt);
      if (exp_issue) checkOutput("imem_addr", imem_addr, pc_tb);
      if (!rst) begin
         checkOutput("instr_valid", instr_valid, expQ.size() != 0);
         if (expQ.size() != 0) begin
            checkOutput("instr_pc", instr_pc, expQ[0].pc);
            checkOutput("instr_data", instr_data, expQ[0].data);
         end else if (prev_rst) begin
            checkOutput("reset_instr_pc", instr_pc, 16'h0000);
            checkOutput("reset_instr_data", instr_data, 16'h0000);
         end
      end

      if (instr_valid && rdy && !redir && !rst) n_pop++;
      if (pc_increment) n_inc++;
      if (imem_req) n_req++;
      grant = imem_req && imem_gnt;

      if (rst) begin
         expQ.delete();
         tracks = 1'b0;
         keep   = 1'b0;
      end else begin
         if (exp_pop && !redir) void'(expQ.pop_front());
         if (rsp_now && tracks) begin
            if (keep && !redir) begin
               ent.pc   = mem_addr;
               ent.data = mem_addr ^ 16'hA5A5;
               expQ.push_back(ent);
            end
            tracks = 1'b0;
            keep   = 1'b0;
         end
         if (redir) begin
            expQ.delete();
            keep = 1'b0;
         end
         if (grant) begin
            tracks = 1'b1;
            keep   = 1'b1;
         end
      end

      if (rsp_now) mem_busy = 1'b0;
      else if (mem_busy) mem_left--;
      if (grant) begin
         mem_busy = 1'b1;
         mem_addr = pc_tb;
         mem_left = lat - 1;
      end

      if (rst || redir) pc_tb = target;
      else if (grant) pc_tb = pc_tb + 16'd1;
      prev_rst = rst;
   endtask

   // Let any memory response drain, then reset with the counter loaded to target.
   task automatic resetDut(input logic [15:0] target);
      repeat (4) applyStimulus(0, 0, 16'h0, 1, 1, 0, 1);
      applyStimulus(1, 0, target, 1, 1, 0, 1);
   endtask

   initial begin
      int got;
      bit found;

      applyStimulus(1, 0, 16'h0000, 0, 1, 0, 1);
      applyStimulus(1, 0, 16'h0000, 0, 1, 0, 1);

      // Streaming with single-cycle memory and an always-ready decoder
      n_pop = 0;
      n_inc = 0;
      repeat (12) applyStimulus(0, 0, 16'h0, 0, 1, 100, 1);
      checkOutput("stream_pops", n_pop, 10);
      checkOutput("stream_increments", n_inc, 12);

      // Decoder stalled: buffer fills to DEPTH, requests stop, nothing lost
      resetDut(16'h0020);
      repeat (5) applyStimulus(0, 0, 16'h0, 0, 0, 100, 1);
      n_req = 0;
      repeat (5) applyStimulus(0, 0, 16'h0, 0, 0, 100, 1);
      checkOutput("stall_no_req", n_req, 0);
      n_pop = 0;
      repeat (6) applyStimulus(0, 0, 16'h0, 1, 1, 100, 1);
      checkOutput("stall_drain_pops", n_pop, DEPTH);

      // Redirect while a grant at 0x0010 is still awaiting data
      resetDut(16'h0010);
      applyStimulus(0, 0, 16'h0, 0, 1, 100, 3);
      applyStimulus(0, 1, 16'h0200, 0, 1, 0, 1);
      found = 1'b0;
      for (int i = 0; i < 12 && !found; i++) begin
         applyStimulus(0, 0, 16'h0, 0, 1, 100, 1);
         if (instr_valid) begin
            checkOutput("redirect_first_pc", instr_pc, 16'h0200);
            found = 1'b1;
         end
      end
      if (!found) checkOutput("redirect_timeout", 0, 1);

      // Redirect coinciding with a response and a pop, two entries buffered
      resetDut(16'h0000);
      repeat (6) applyStimulus(0, 0, 16'h0, 0, 0, 100, 2);
      applyStimulus(0, 1, 16'h0300, 0, 1, 100, 1);
      checkOutput("redirect_rsp_no_inc", pc_increment, 0);
      applyStimulus(0, 0, 16'h0, 1, 1, 100, 1);
      checkOutput("redirect_rsp_flushed", instr_valid, 0);

      // Halt with one request outstanding
      resetDut(16'h0040);
      applyStimulus(0, 0, 16'h0, 0, 1, 100, 3);
      n_req = 0;
      n_pop = 0;
      repeat (6) applyStimulus(0, 0, 16'h0, 1, 1, 100, 1);
      checkOutput("halt_no_req", n_req, 0);
      checkOutput("halt_delivered", n_pop, 1);
      applyStimulus(0, 0, 16'h0, 0, 1, 100, 1);
      checkOutput("resume_req", imem_req, 1);
      checkOutput("resume_addr", imem_addr, 16'h0041);

      // Reset while waiting; late response ignored; fetch wraps past 0xFFFF
      resetDut(16'h0000);
      applyStimulus(0, 0, 16'h0, 0, 1, 100, 3);
      applyStimulus(1, 0, 16'hFFFF, 0, 1, 0, 1);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 16'h0, 1, 1, 100, 1);
         checkOutput("late_rsp_ignored", instr_valid, 0);
      end
      got = 0;
      for (int i = 0; i < 10 && got < 2; i++) begin
         applyStimulus(0, 0, 16'h0, 0, 1, 100, 1);
         if (instr_valid) begin
            checkOutput(got == 0 ? "wrap_pc_ffff" : "wrap_pc_0000", instr_pc,
                        got == 0 ? 16'hFFFF : 16'h0000);
            got++;
         end
      end
      if (got < 2) checkOutput("wrap_timeout", got, 2);

      // Randomized traffic against the reference model
      for (int i = 0; i < 400; i++) begin
         applyStimulus($urandom_range(99) < 2, $urandom_range(99) < 6, 16'($urandom),
                       $urandom_range(99) < 15, $urandom_range(99) < 70, 70,
                       $urandom_range(3, 1));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not complete");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage of the VR16 frontend, between the program counter and the decoder. Takes the current PC, issues word reads to instruction memory over a request/grant/response handshake, and pulses the counter's increment input once per accepted request. A small FIFO holds returned instruction/PC pairs for the decoder under a valid/ready handshake. Jumps and returns flush the FIFO and discard any in-flight response.

## Interface
Parameters:
- DEPTH, 2: instruction FIFO entries; legal values 2 or 4.
- XLEN, 16: address and instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- pc  in  XLEN  current counter value from program_counter.
- redirect  in  1  jump or return taken this cycle; flushes the stage.
- halt  in  1  level; stops new requests; in-flight and buffered entries still complete.
- pc_increment  out  1  one-cycle pulse when memory grants a request.
- imem_req  out  1  read request.
- imem_addr  out  XLEN  read address; equals pc while imem_req is high.
- imem_gnt  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; at most one response per grant, in order, at least 1 cycle after grant.
- imem_rdata  in  XLEN  instruction word.
- instr_valid  out  1  FIFO head is valid.
- instr_ready  in  1  decoder accepts the head.
- instr_data  out  XLEN  instruction at FIFO head.
- instr_pc  out  XLEN  address the head was fetched from.

## Operation
- In-flight FSM: IDLE (nothing outstanding), WAIT (one granted request awaiting data), DROP (one granted request whose data is discarded).
- At most one outstanding request. outstanding = (state != IDLE).
- issue = !reset && !halt && !redirect && (state == IDLE || (state == WAIT && imem_rvalid)) && (count + outstanding - (instr_valid && instr_ready) < DEPTH).
- imem_req = issue (combinational); imem_addr = pc. Memory tolerates withdrawal of an ungranted request.
- pc_increment = imem_req && imem_gnt. Each grant records the granted address as the pending PC.
- IDLE -> WAIT on grant. WAIT + rvalid: push {pending PC, rdata}; -> WAIT on a new grant, else IDLE. DROP + rvalid: discard; -> IDLE (no issue from DROP).
- redirect: clear FIFO (count 0); WAIT -> DROP; DROP stays DROP; a WAIT-state rvalid in the same cycle is discarded (-> IDLE). Any pop that cycle is void.
- rvalid in IDLE is ignored (covers responses arriving after reset).
- FIFO: push and pop in the same cycle are legal at any occupancy, including full. Pop only when instr_valid && instr_ready.
- Wrap-around: pending PC 16'hFFFF is legal; the counter wraps, not this block.

## Timing
- Reset values: state IDLE, count 0, instr_valid 0, instr_data 0, instr_pc 0, pc_increment 0, imem_req 0.
- Reset mid-operation clears everything within one edge. Any outstanding response is then ignored.
- Response at cycle t appears on instr_valid/instr_data at t+1. The FIFO is not bypassed.
- Full throughput with 1-cycle memory and a ready decoder: one instruction per cycle after a 2-cycle startup.
- pc advances the edge after pc_increment, so a back-to-back issue presents the next address.
- redirect at cycle t: instr_valid low at t+1; first new request no earlier than t+1, using the new pc.

## Structure
- Shared package vr16_pkg: XLEN, fetch FSM state encoding (IDLE/WAIT/DROP), and a {pc, instr} fetch-entry bundle width.
- One sub-module: fetch_fifo (DEPTH-entry synchronous FIFO with push, pop, flush, count, head outputs). The FSM, issue logic and pending-PC register live in instruction_fetch.

## Test plan
- Reset, then 1-cycle memory returning addr ^ 16'hA5A5, decoder always ready, pc starting 0 -> instr_pc 0,1,2,3 on consecutive cycles with matching data; one pc_increment per grant.
- Decoder ready low for 10 cycles -> exactly DEPTH entries buffered, imem_req low thereafter, no data lost or duplicated on release.
- Grant at pc 16'h0010, redirect to 16'h0200 before rvalid -> the 16'h0010 response is dropped; the next instr_pc is 16'h0200.
- redirect in the same cycle as rvalid and a pop with 2 entries buffered -> instr_valid 0 next cycle; count 0; no pc_increment that cycle.
- halt held with 1 request outstanding -> response still delivered, no new imem_req; deassert halt -> fetch resumes at current pc.
- reset asserted while in WAIT, memory returns rvalid 2 cycles later -> response ignored, instr_valid stays 0, FSM IDLE; pc 16'hFFFF fetch then wraps to 16'h0000.
